// File: rtl/aes_sched_pkg.sv
// ============================================================================
// Module      : aes_sched_pkg
// Description : Shared widths and the round-robin pick helper for the
//               AES-256 core scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_sched_pkg;

    localparam int STATE_W = 128;
    localparam int KEY_W   = 256;
    localparam int MAX_REQ = 32;

    // Returns 1 when any requester is valid; idx is the first valid one
    // found scanning ptr, ptr+1, ... modulo n.
    function automatic logic rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input int ptr,
                                     input int n,
                                     output int idx);
        logic found;
        int   c;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            c = ptr + k;
            if (c >= n) c = c - n;
            if (!found && (k < n) && valid[c[4:0]]) begin
                found = 1'b1;
                idx   = c;
            end
        end
        return found;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_256_sched_if.sv
// ============================================================================
// Module      : aes_256_sched_if
// Description : Requester, core and response signals of the AES-256 scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_256_sched_if
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*STATE_W-1:0] req_state;
    logic [NUM_REQ*KEY_W-1:0]   req_key;
    logic [STATE_W-1:0]         core_state;
    logic [KEY_W-1:0]           core_key;
    logic [STATE_W-1:0]         core_out;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [STATE_W-1:0]         rsp_data;
    logic [ID_W-1:0]            rsp_id;

    modport slave (
        input  req_valid, req_state, req_key, core_out, rsp_ready,
        output req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_state, req_key, core_out, rsp_ready,
        input  req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id
    );
endinterface

`default_nettype wire

// File: rtl/aes_rsp_fifo.sv
// ============================================================================
// Module      : aes_rsp_fifo
// Description : Synchronous FIFO, no fall-through, push/pop legal together.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rsp_fifo #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 20,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop_ok;

    function automatic logic [c_PTR_W-1:0] nxt(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_count  = r_count;
    assign w_pop_ok = i_pop && !o_empty;
    assign o_rdata  = r_mem[r_rd_ptr];

    // At full, a same-cycle pop frees the head slot that the push lands in.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)   r_wr_ptr <= nxt(r_wr_ptr);
            if (w_pop_ok) r_rd_ptr <= nxt(r_rd_ptr);
            case ({i_push, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/aes_256_sched.sv
// ============================================================================
// Module      : aes_256_sched
// Description : Round-robin, credit-gated sharing of one pipelined AES-256 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_256_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CORE_LAT   = 17,
    parameter int FIFO_DEPTH = 20,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input wire logic        clk,
    input wire logic        rst_n,
    aes_256_sched_if.slave  bus
);
    localparam int c_CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENT_W  = STATE_W + ID_W;
    // Stage 0 loads alongside the issue registers, so one extra stage lines
    // the tail up with the core output for that block.
    localparam int c_PIPE_D = CORE_LAT + 1;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } pipe_ent_t;

    logic [c_CRED_W-1:0] r_credit;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [STATE_W-1:0]  r_core_state;
    logic [KEY_W-1:0]    r_core_key;
    pipe_ent_t           r_pipe [c_PIPE_D];

    logic                w_found;
    int                  w_idx;
    logic                w_grant;
    logic [ID_W-1:0]     w_win;
    logic [NUM_REQ-1:0]  w_ready;
    pipe_ent_t           w_tail;
    logic                w_push;
    logic                w_pop;
    logic [c_ENT_W-1:0]  w_rdata;
    logic [c_CRED_W-1:0] w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused_stat;

    always_comb begin
        w_idx   = 0;
        w_ready = '0;
        w_found = rr_pick(MAX_REQ'(bus.req_valid), int'(r_rr_ptr), NUM_REQ, w_idx);
        w_grant = w_found && (r_credit != '0);
        w_win   = ID_W'(w_idx);
        if (w_grant) w_ready[w_win] = 1'b1;
    end

    assign bus.req_ready  = w_ready;
    assign bus.core_state = r_core_state;
    assign bus.core_key   = r_core_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_credit     <= c_CRED_W'(FIFO_DEPTH);
            r_core_state <= '0;
            r_core_key   <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr     <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                r_core_state <= bus.req_state[w_win*STATE_W +: STATE_W];
                r_core_key   <= bus.req_key[w_win*KEY_W +: KEY_W];
            end
            case ({w_grant, w_pop})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_PIPE_D; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= '{v: w_grant, id: w_win};
            for (int k = 1; k < c_PIPE_D; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign w_tail = r_pipe[CORE_LAT];
    assign w_push = w_tail.v;
    assign w_pop  = bus.rsp_valid && bus.rsp_ready;

    aes_rsp_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CRED_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({bus.core_out, w_tail.id}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.rsp_valid = !w_fifo_empty;
    assign bus.rsp_data  = w_rdata[c_ENT_W-1 -: STATE_W];
    assign bus.rsp_id    = w_rdata[ID_W-1:0];

    // Credit already guarantees room; occupancy is kept for observation only.
    assign w_unused_stat = ^{w_fifo_count, w_fifo_full};
endmodule

`default_nettype wire

// File: tb/tb_aes_256_sched.sv
// ============================================================================
// Module      : tb_aes_256_sched
// Description : Directed bench; two scheduler instances (depth 20 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_256_sched;
    localparam int LAT = 17;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_256_sched_if #(.NUM_REQ(4)) ia ();
    aes_256_sched_if #(.NUM_REQ(4)) ib ();

    aes_256_sched #(.NUM_REQ(4), .CORE_LAT(LAT), .FIFO_DEPTH(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    aes_256_sched #(.NUM_REQ(4), .CORE_LAT(LAT), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    logic [3:0]   req_valid;
    logic [127:0] st [4];
    logic [255:0] ky [4];
    logic [511:0] st_flat;
    logic [1023:0] ky_flat;
    logic rsp_ready_a, rsp_ready_b;

    always_comb begin
        st_flat = '0;
        ky_flat = '0;
        for (int i = 0; i < 4; i++) begin
            st_flat[i*128 +: 128] = st[i];
            ky_flat[i*256 +: 256] = ky[i];
        end
    end

    assign ia.req_valid = req_valid;  assign ib.req_valid = req_valid;
    assign ia.req_state = st_flat;    assign ib.req_state = st_flat;
    assign ia.req_key   = ky_flat;    assign ib.req_key   = ky_flat;
    assign ia.rsp_ready = rsp_ready_a;
    assign ib.rsp_ready = rsp_ready_b;

    // Core stand-in: known answer for the C.3 vector, a keyed XOR otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [255:0] k);
        if (s == C3_PT && k == C3_KEY) return C3_CT;
        return s ^ k[127:0] ^ k[255:128];
    endfunction

    logic [127:0] cma [LAT];
    logic [127:0] cmb [LAT];
    always @(posedge clk) begin
        cma[0] <= core_f(ia.core_state, ia.core_key);
        cmb[0] <= core_f(ib.core_state, ib.core_key);
        for (int k = 1; k < LAT; k++) begin
            cma[k] <= cma[k-1];
            cmb[k] <= cmb[k-1];
        end
    end
    assign ia.core_out = cma[LAT-1];
    assign ib.core_out = cmb[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           ga_q[$], ga_cyc[$], gb_q[$];
    int           ra_id[$], ra_cyc[$], rb_id[$];
    logic [127:0] ra_dat[$], rb_dat[$];
    int           ovf_a = 0, ovf_b = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (ia.req_valid[i] && ia.req_ready[i]) begin ga_q.push_back(i); ga_cyc.push_back(cyc); end
                if (ib.req_valid[i] && ib.req_ready[i]) gb_q.push_back(i);
            end
            if (ia.rsp_valid && ia.rsp_ready) begin
                ra_id.push_back(int'(ia.rsp_id)); ra_dat.push_back(ia.rsp_data); ra_cyc.push_back(cyc);
            end
            if (ib.rsp_valid && ib.rsp_ready) begin
                rb_id.push_back(int'(ib.rsp_id)); rb_dat.push_back(ib.rsp_data);
            end
            if (dut_a.w_push && dut_a.w_fifo_full && !dut_a.w_pop) ovf_a++;
            if (dut_b.w_push && dut_b.w_fifo_full && !dut_b.w_pop) ovf_b++;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = 4'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ga_q.delete(); ga_cyc.delete(); gb_q.delete();
        ra_id.delete(); ra_dat.delete(); ra_cyc.delete();
        rb_id.delete(); rb_dat.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready_a = 1'b1;
        rsp_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i] = {4{32'h5a00_0000 + 32'(i)}};
            ky[i] = {{4{32'hc0de_0000 + 32'(i)}}, {4{32'h1234_0000}}};
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  256'(ia.req_ready), 256'(0));
        chk("rst_rsp_valid",  256'(ia.rsp_valid), 256'(0));
        chk("rst_core_state", 256'(ia.core_state), 256'(0));
        chk("rst_core_key",   ia.core_key, 256'(0));
        chk("rst_credit_a",   256'(dut_a.r_credit), 256'(20));
        chk("rst_credit_b",   256'(dut_b.r_credit), 256'(4));
        chk("rst_rr_ptr",     256'(dut_a.r_rr_ptr), 256'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: single C.3 block from requester 0
        do_reset();
        st[0] = C3_PT; ky[0] = C3_KEY;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_grant", 256'(ia.req_ready), 256'(4'b0001));
        @(posedge clk); #1 req_valid = '0;
        for (int n = 0; n < 40 && ra_id.size() == 0; n++) @(posedge clk);
        chk("t1_rsp_count", 256'(ra_id.size()), 256'(1));
        if (ra_id.size() > 0 && ga_cyc.size() > 0) begin
            chk("t1_rsp_data", 256'(ra_dat[0]), 256'(C3_CT));
            chk("t1_rsp_id",   256'(ra_id[0]), 256'(0));
            chk("t1_latency",  256'(ra_cyc[0] - ga_cyc[0]), 256'(LAT + 2));
        end

        // 2: all requesters for 12 cycles, back-to-back results
        for (int i = 0; i < 4; i++) begin
            st[i] = {4{32'h5a00_0000 + 32'(i)}};
            ky[i] = {{4{32'hc0de_0000 + 32'(i)}}, {4{32'h1234_0000}}};
        end
        do_reset();
        req_valid = 4'hf;
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        for (int n = 0; n < 60 && ra_id.size() < 12; n++) @(posedge clk);
        chk("t2_grant_count", 256'(ga_q.size()), 256'(12));
        for (int k = 0; k < 12 && k < ga_q.size(); k++)
            chk($sformatf("t2_grant%0d", k), 256'(ga_q[k]), 256'(k % 4));
        chk("t2_rsp_count", 256'(ra_id.size()), 256'(12));
        for (int k = 0; k < 12 && k < ra_id.size(); k++) begin
            chk($sformatf("t2_rsp_id%0d", k), 256'(ra_id[k]), 256'(k % 4));
            chk($sformatf("t2_rsp_data%0d", k), 256'(ra_dat[k]), 256'(core_f(st[k % 4], ky[k % 4])));
        end
        if (ra_cyc.size() == 12)
            chk("t2_no_bubble", 256'(ra_cyc[11] - ra_cyc[0]), 256'(11));
        @(negedge clk);
        chk("t2_credit_back", 256'(dut_a.r_credit), 256'(20));

        // 3: depth-4 instance with the consumer stalled
        rsp_ready_b = 1'b0;
        do_reset();
        req_valid = 4'hf;
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_grant_count", 256'(gb_q.size()), 256'(4));
        for (int k = 0; k < 4 && k < gb_q.size(); k++)
            chk($sformatf("t3_grant%0d", k), 256'(gb_q[k]), 256'(k));
        chk("t3_ready_off", 256'(ib.req_ready), 256'(0));
        chk("t3_count",     256'(dut_b.w_fifo_count), 256'(4));
        chk("t3_credit",    256'(dut_b.r_credit), 256'(0));
        chk("t3_head_id",   256'(ib.rsp_id), 256'(0));
        chk("t3_head_data", 256'(ib.rsp_data), 256'(core_f(st[0], ky[0])));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_hold_id",   256'(ib.rsp_id), 256'(0));
        chk("t3_hold_data", 256'(ib.rsp_data), 256'(core_f(st[0], ky[0])));

        // 4: one pop from a full FIFO with all requesters still valid
        @(posedge clk); #1 rsp_ready_b = 1'b1;
        @(negedge clk);
        chk("t4_no_grant_on_pop", 256'(ib.req_ready), 256'(0));
        @(posedge clk); #1 rsp_ready_b = 1'b0;
        @(negedge clk);
        chk("t4_regrant",   256'(ib.req_ready), 256'(4'b0001));
        chk("t4_credit1",   256'(dut_b.r_credit), 256'(1));
        chk("t4_count3",    256'(dut_b.w_fifo_count), 256'(3));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_single",    256'(ib.req_ready), 256'(0));
        chk("t4_grants",    256'(gb_q.size()), 256'(5));
        repeat (25) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_refull",    256'(dut_b.w_fifo_count), 256'(4));
        chk("t4_credit0",   256'(dut_b.r_credit), 256'(0));
        @(posedge clk); #1 req_valid = '0; rsp_ready_b = 1'b1;
        for (int n = 0; n < 40 && rb_id.size() < 5; n++) @(posedge clk);
        chk("t4_drain_count", 256'(rb_id.size()), 256'(5));
        for (int k = 0; k < 5 && k < rb_id.size(); k++) begin
            chk($sformatf("t4_drain_id%0d", k), 256'(rb_id[k]), 256'(k % 4));
            chk($sformatf("t4_drain_data%0d", k), 256'(rb_dat[k]), 256'(core_f(st[k % 4], ky[k % 4])));
        end
        chk("t4_overflow", 256'(ovf_b), 256'(0));

        // 5: reset with results queued and blocks in flight
        rsp_ready_a = 1'b0;
        do_reset();
        req_valid = 4'hf;
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t5_pre_valid", 256'(ia.rsp_valid), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",  256'(ia.rsp_valid), 256'(0));
        chk("t5_rst_credit", 256'(dut_a.r_credit), 256'(20));
        chk("t5_rst_core",   256'(ia.core_state), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ga_q.delete(); ga_cyc.delete(); ra_id.delete(); ra_dat.delete(); ra_cyc.delete();
        st[2] = C3_PT; ky[2] = C3_KEY;
        rsp_ready_a = 1'b1;
        req_valid = 4'b0100;
        @(posedge clk); #1 req_valid = '0;
        repeat (40) @(posedge clk);
        chk("t5_rsp_count", 256'(ra_id.size()), 256'(1));
        if (ra_id.size() > 0) begin
            chk("t5_rsp_id",   256'(ra_id[0]), 256'(2));
            chk("t5_rsp_data", 256'(ra_dat[0]), 256'(C3_CT));
        end

        // 6: only requester 3 valid with rr_ptr at 1
        do_reset();
        req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = 4'b1000;
        @(negedge clk);
        chk("t6_ptr1",  256'(dut_a.r_rr_ptr), 256'(1));
        chk("t6_grant", 256'(ia.req_ready), 256'(4'b1000));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t6_wrap",  256'(dut_a.r_rr_ptr), 256'(0));
        chk("overflow_a", 256'(ovf_a), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
